// File: rtl/dummy_stream_tester_if.sv
// AXI-Stream bundle used on both sides of the stream tester.
interface dummy_stream_tester_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dummy_stream_tester.sv
// Self-checking AXI-Stream endpoint: sends one incrementing packet per start and checks it back.
// Optional LFSR valid/ready throttling is enabled by defining STREAM_TESTER_THROTTLE_EN.
module dummy_stream_tester #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_cnt,
  dummy_stream_tester_if.master m_axi,
  dummy_stream_tester_if.slave  s_axi
);

  localparam int unsigned KeepWidth = DATA_WIDTH / 8;
  localparam logic [KeepWidth-1:0]  KeepAll = '1;
  localparam logic [LEN_WIDTH-1:0]  LenOne  = LEN_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DataOne = DATA_WIDTH'(1);

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SEND  = 1'b1;
  localparam logic [0:0] RX_IDLE  = 1'b0;
  localparam logic [0:0] RX_CHECK = 1'b1;

  logic                  tx_gate;
  logic                  rx_ready;

  logic [0:0]            tx_state_q, tx_state_d;
  logic [LEN_WIDTH-1:0]  tx_idx_q, tx_idx_d;
  logic [LEN_WIDTH-1:0]  tx_len_q, tx_len_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [KeepWidth-1:0]  tx_keep_q, tx_keep_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last_q, tx_last_d;

  logic [0:0]            rx_state_q, rx_state_d;
  logic [LEN_WIDTH-1:0]  rx_idx_q, rx_idx_d;
  logic [LEN_WIDTH-1:0]  rx_len_q, rx_len_d;
  logic [DATA_WIDTH-1:0] rx_exp_q, rx_exp_d;
  logic [15:0]           err_q, err_d;
  logic                  done_q, done_d;

  logic start_acc;
  logic tx_hs;
  logic rx_hs;
  logic rx_last_exp;
  logic beat_err;

`ifdef STREAM_TESTER_THROTTLE_EN
  logic [7:0] lfsr_q;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign tx_gate  = lfsr_q[0];
  assign rx_ready = lfsr_q[1];
`else
  assign tx_gate  = 1'b1;
  assign rx_ready = 1'b1;
`endif

  // Both sides must be idle, and the done cycle itself never accepts a new start.
  assign start_acc = start && (tx_state_q == TX_IDLE) && (rx_state_q == RX_IDLE) &&
                     !done_q && (pkt_len != '0);
  assign tx_hs     = tx_valid_q && m_axi.tready;
  assign rx_hs     = s_axi.tvalid && rx_ready;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_len_d   = tx_len_q;
    tx_data_d  = tx_data_q;
    tx_keep_d  = tx_keep_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (start_acc) begin
          tx_state_d = TX_SEND;
          tx_idx_d   = '0;
          tx_len_d   = pkt_len;
          tx_data_d  = seed;
          tx_keep_d  = KeepAll;
          tx_last_d  = (pkt_len == LenOne);
          tx_valid_d = tx_gate;
        end
      end
      TX_SEND: begin
        if (tx_hs) begin
          if (tx_last_q) begin
            tx_state_d = TX_IDLE;
            tx_valid_d = 1'b0;
          end else begin
            tx_idx_d   = tx_idx_q + LenOne;
            tx_data_d  = tx_data_q + DataOne;
            tx_last_d  = ((tx_idx_q + LenOne) == (tx_len_q - LenOne));
            tx_valid_d = tx_gate;
          end
        end else if (!tx_valid_q) begin
          tx_valid_d = tx_gate;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign rx_last_exp = (rx_idx_q == (rx_len_q - LenOne));

  // Any field mismatch is one error; every beat outside a check window is stray.
  always_comb begin
    if (rx_state_q == RX_CHECK) begin
      beat_err = (s_axi.tdata != rx_exp_q) || (s_axi.tkeep != KeepAll) ||
                 (s_axi.tlast != rx_last_exp);
    end else begin
      beat_err = 1'b1;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    rx_len_d   = rx_len_q;
    rx_exp_d   = rx_exp_q;
    done_d     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (start_acc) begin
          rx_state_d = RX_CHECK;
          rx_idx_d   = '0;
          rx_len_d   = pkt_len;
          rx_exp_d   = seed;
        end
      end
      RX_CHECK: begin
        if (rx_hs) begin
          if (rx_last_exp) begin
            rx_state_d = RX_IDLE;
            done_d     = 1'b1;
          end else begin
            rx_idx_d = rx_idx_q + LenOne;
            rx_exp_d = rx_exp_q + DataOne;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (start_acc) begin
      err_d = rx_hs ? 16'd1 : 16'd0;
    end else if (rx_hs && beat_err && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      tx_len_q   <= '0;
      tx_data_q  <= '0;
      tx_keep_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_idx_q   <= '0;
      rx_len_q   <= '0;
      rx_exp_q   <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_len_q   <= tx_len_d;
      tx_data_q  <= tx_data_d;
      tx_keep_q  <= tx_keep_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_len_q   <= rx_len_d;
      rx_exp_q   <= rx_exp_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign m_axi.tdata  = tx_data_q;
  assign m_axi.tkeep  = tx_keep_q;
  assign m_axi.tvalid = tx_valid_q;
  assign m_axi.tlast  = tx_last_q;
  assign s_axi.tready = rx_ready;

  assign busy    = (rx_state_q == RX_CHECK);
  assign done    = done_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_dummy_stream_tester.sv
// Directed bench: loops the tester through a one-stage register slice, with stall,
// corruption, stray-beat injection and mid-packet reset cases.
module tb_dummy_stream_tester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  pkt_len;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic [15:0] err_cnt;

  logic        sink_rdy, inj_mode, inj_valid, inj_last, corrupt_en;
  logic [31:0] inj_data, corrupt_val;
  logic        sl_valid, sl_last;
  logic [31:0] sl_data;
  logic [3:0]  sl_keep;

  logic [31:0] log_data [64];
  logic        log_last [64];
  int          tx_n = 0;
  int          done_cnt = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          base, dbase;
  bit          ok;
  logic        exp_rdy;

  dummy_stream_tester_if #(.DATA_WIDTH(32)) m_if ();
  dummy_stream_tester_if #(.DATA_WIDTH(32)) s_if ();

  dummy_stream_tester #(.DATA_WIDTH(32), .LEN_WIDTH(10)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .start   (start),
    .pkt_len (pkt_len),
    .seed    (seed),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .m_axi   (m_if),
    .s_axi   (s_if)
  );

  always #5 clk = ~clk;

  assign m_if.tready = sink_rdy && (!sl_valid || s_if.tready);
  assign s_if.tvalid = inj_mode ? inj_valid : sl_valid;
  assign s_if.tdata  = inj_mode ? inj_data  : sl_data;
  assign s_if.tkeep  = inj_mode ? 4'hF      : sl_keep;
  assign s_if.tlast  = inj_mode ? inj_last  : sl_last;

  always @(posedge clk) begin
    if (!rst_n) begin
      sl_valid <= 1'b0;
    end else if (m_if.tvalid && m_if.tready) begin
      sl_valid <= 1'b1;
      sl_data  <= m_if.tdata ^ ((corrupt_en && m_if.tdata == corrupt_val) ? 32'h1 : 32'h0);
      sl_keep  <= m_if.tkeep;
      sl_last  <= m_if.tlast;
    end else if (sl_valid && s_if.tready && !inj_mode) begin
      sl_valid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready && tx_n < 64) begin
      log_data[tx_n] <= m_if.tdata;
      log_last[tx_n] <= m_if.tlast;
      tx_n <= tx_n + 1;
    end
    if (rst_n && done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done, then one more cycle so a following start is not in the done cycle.
  task automatic wait_done(input int max);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(ok), 64'd1);
    @(negedge clk);
  endtask

  initial begin
`ifdef STREAM_TESTER_THROTTLE_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    rst_n = 0; start = 0; pkt_len = 0; seed = 0; sink_rdy = 1;
    inj_mode = 0; inj_valid = 0; inj_data = 0; inj_last = 0; corrupt_en = 0; corrupt_val = 0;
    repeat (3) @(negedge clk);
    chk("rst_tdata", 64'(m_if.tdata), 64'd0);
    chk("rst_tkeep", 64'(m_if.tkeep), 64'd0);
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    chk("rst_tready", 64'(s_if.tready), 64'(exp_rdy));
    rst_n = 1;
    @(negedge clk);

    // Basic loopback, seed 0x10, 4 beats
    base = tx_n; dbase = done_cnt;
    seed = 32'h10; pkt_len = 4; start = 1;
    @(negedge clk); start = 0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_tvalid", 64'(m_if.tvalid), 64'd1);
    chk("t1_tdata0", 64'(m_if.tdata), 64'h10);
    chk("t1_tlast0", 64'(m_if.tlast), 64'd0);
    repeat (4) @(negedge clk);
    chk("t1_done_early", 64'(done), 64'd0);
    chk("t1_busy_hold", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_busy_fall", 64'(busy), 64'd0);
    chk("t1_err", 64'(err_cnt), 64'd0);
    // Start in the done cycle is ignored, accepted one cycle later
    seed = 32'h20; pkt_len = 2; start = 1;
    @(negedge clk);
    chk("t1_start_in_done", 64'(busy), 64'd0);
    @(negedge clk); start = 0;
    chk("t1_start_next", 64'(busy), 64'd1);
    chk("t1_tdata_p2", 64'(m_if.tdata), 64'h20);
    wait_done(20);
    chk("t1_err_p2", 64'(err_cnt), 64'd0);
    chk("t1_beats", 64'(tx_n - base), 64'd6);
    for (int i = 0; i < 4; i++) begin
      chk("t1_log_data", 64'(log_data[base + i]), 64'(32'h10 + i));
      chk("t1_log_last", 64'(log_last[base + i]), 64'(i == 3));
    end
    chk("t1_log_p2a", 64'(log_data[base + 4]), 64'h20);
    chk("t1_log_p2b", 64'(log_data[base + 5]), 64'h21);
    chk("t1_done_cnt", 64'(done_cnt - dbase), 64'd2);

    // Sink stall of 5 cycles mid-packet
    base = tx_n;
    seed = 32'd100; pkt_len = 8; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk); sink_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(m_if.tvalid), 64'd1);
      chk("t2_hold_data", 64'(m_if.tdata), 64'd102);
    end
    sink_rdy = 1;
    wait_done(40);
    chk("t2_err", 64'(err_cnt), 64'd0);
    chk("t2_beats", 64'(tx_n - base), 64'd8);
    for (int i = 0; i < 8; i++) chk("t2_log_data", 64'(log_data[base + i]), 64'(100 + i));

    // Corrupt beat 2 (data 202) in the return path
    dbase = done_cnt;
    corrupt_en = 1; corrupt_val = 32'd202;
    seed = 32'd200; pkt_len = 8; start = 1;
    @(negedge clk); start = 0;
    wait_done(40);
    corrupt_en = 0;
    chk("t3_err", 64'(err_cnt), 64'd1);
    chk("t3_done_once", 64'(done_cnt - dbase), 64'd1);
    chk("t3_done_low", 64'(done), 64'd0);

    // Data wrap-around
    base = tx_n;
    seed = 32'hFFFF_FFFE; pkt_len = 3; start = 1;
    @(negedge clk); start = 0;
    chk("t4_err_clear", 64'(err_cnt), 64'd0);
    wait_done(20);
    chk("t4_err", 64'(err_cnt), 64'd0);
    chk("t4_d0", 64'(log_data[base]), 64'hFFFF_FFFE);
    chk("t4_d1", 64'(log_data[base + 1]), 64'hFFFF_FFFF);
    chk("t4_d2", 64'(log_data[base + 2]), 64'h0);
    chk("t4_last", 64'(log_last[base + 2]), 64'd1);

    // Stray beat while idle, then stray coincident with start
    inj_mode = 1; inj_valid = 1; inj_data = 32'h0; inj_last = 0;
    @(negedge clk); inj_mode = 0; inj_valid = 0;
    chk("t5_stray", 64'(err_cnt), 64'd1);
    chk("t5_stray_busy", 64'(busy), 64'd0);
    inj_mode = 1; inj_valid = 1;
    seed = 32'd5; pkt_len = 1; start = 1;
    @(negedge clk); start = 0; inj_mode = 0; inj_valid = 0;
    chk("t5_start_stray", 64'(err_cnt), 64'd1);
    chk("t5_busy", 64'(busy), 64'd1);
    wait_done(20);
    chk("t5_err_end", 64'(err_cnt), 64'd1);

    // Early TLAST on beat 0, missing TLAST on beat 1, then TX drains as stray
    sink_rdy = 0;
    seed = 32'd50; pkt_len = 2; start = 1;
    @(negedge clk); start = 0;
    inj_mode = 1; inj_valid = 1; inj_data = 32'd50; inj_last = 1;
    @(negedge clk); inj_data = 32'd51; inj_last = 0;
    @(negedge clk); inj_mode = 0; inj_valid = 0;
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_err_tlast", 64'(err_cnt), 64'd2);
    sink_rdy = 1;
    repeat (5) @(negedge clk);
    chk("t6_err_stray", 64'(err_cnt), 64'd4);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_tvalid", 64'(m_if.tvalid), 64'd0);

    // Reset after two beats, then a one-beat packet
    base = tx_n;
    seed = 32'h300; pkt_len = 8; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk); rst_n = 0;
    @(negedge clk);
    chk("t7_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("t7_tdata", 64'(m_if.tdata), 64'd0);
    chk("t7_tkeep", 64'(m_if.tkeep), 64'd0);
    chk("t7_tlast", 64'(m_if.tlast), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_done", 64'(done), 64'd0);
    chk("t7_err", 64'(err_cnt), 64'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    seed = 32'd7; pkt_len = 1; start = 1;
    @(negedge clk); start = 0;
    chk("t7_new_data", 64'(m_if.tdata), 64'd7);
    chk("t7_new_last", 64'(m_if.tlast), 64'd1);
    wait_done(20);
    chk("t7_new_err", 64'(err_cnt), 64'd0);
    chk("t7_beats", 64'(tx_n - base), 64'd3);
    chk("t7_log_data", 64'(log_data[base + 2]), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
